// File: rtl/bit_stream_pkg.sv
// Shared types and defaults for the bit-stream frame synchroniser.
package bit_stream_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_VERIFY, S_LOCKED} sync_state_e;

  localparam logic [3:0] DEF_SYNC_WORD = 4'b1001;

endpackage

// File: rtl/sync_word_match.sv
// Sync-word shift register and comparator; hit is combinational on the bit being accepted.
// Optional SYNC_INVERT_EN adds a match on the inverted sync word.
module sync_word_match
  import bit_stream_pkg::*;
#(
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_vld,
  input  logic i_din,
`ifdef SYNC_INVERT_EN
  output logic o_hit_inv,
`endif
  output logic o_hit
);

  // Only the previous SYNC_W-1 bits need storing; the incoming bit completes the word.
  logic [SYNC_W-2:0] r_sr;
  logic [SYNC_W-1:0] w_word;

  assign w_word = {r_sr, i_din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_vld) begin
      r_sr <= w_word[SYNC_W-2:0];
    end
  end

  assign o_hit = i_vld && (w_word == SYNC_WORD);

`ifdef SYNC_INVERT_EN
  assign o_hit_inv = i_vld && (w_word == ~SYNC_WORD);
`endif

endmodule

// File: rtl/bit_stream_sync_ctrl.sv
// Frame sync controller (hunt/verify/lock, flywheel, sync stripping); optional SYNC_INVERT_EN.
// Outputs registered one cycle after each valid bit; din_valid=0 freezes all state, pulses drop.
module bit_stream_sync_ctrl
  import bit_stream_pkg::*;
#(
  parameter int                SYNC_W      = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
  parameter int                FRAME_LEN   = 16,
  parameter int                CONFIRM_CNT = 2,
  parameter int                MISS_CNT    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         din_valid,
  input  logic                         din,
  output logic                         locked,
  output logic                         dout_valid,
  output logic                         dout,
  output logic [$clog2(FRAME_LEN)-1:0] bit_idx,
  output logic                         frame_start,
`ifdef SYNC_INVERT_EN
  output logic                         inv_pol,
`endif
  output logic                         sync_lost
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int CW = $clog2(CONFIRM_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(FRAME_LEN - SYNC_W - 1);
  localparam logic [CW-1:0] CONF_TGT = CW'(CONFIRM_CNT);
  localparam logic [MW-1:0] MISS_TGT = MW'(MISS_CNT);

  sync_state_e   r_state;
  logic [PW-1:0] r_pos;
  logic [CW-1:0] r_conf;
  logic [MW-1:0] r_miss;
  logic          r_locked;
  logic          r_dout_vld;
  logic          r_dout;
  logic [PW-1:0] r_bit_idx;
  logic          r_frame_start;
  logic          r_sync_lost;

  logic          w_hit;
  logic          w_hunt_hit;
  logic          w_cp_hit;
  logic          w_dbit;
  logic          w_chk;
  logic          w_payload;
  logic [PW-1:0] w_pos_nxt;
  logic [CW-1:0] w_conf_inc;
  logic [MW-1:0] w_miss_inc;

`ifdef SYNC_INVERT_EN
  logic          w_hit_inv;
  logic          r_inv;
`endif

  sync_word_match #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!enable),
    .i_vld     (din_valid),
    .i_din     (din),
`ifdef SYNC_INVERT_EN
    .o_hit_inv (w_hit_inv),
`endif
    .o_hit     (w_hit)
  );

  // Once locked to a polarity, checkpoints only accept a word of that same polarity.
`ifdef SYNC_INVERT_EN
  assign w_hunt_hit = w_hit | w_hit_inv;
  assign w_cp_hit   = r_inv ? w_hit_inv : w_hit;
  assign w_dbit     = din ^ r_inv;
  assign inv_pol    = r_locked & r_inv;
`else
  assign w_hunt_hit = w_hit;
  assign w_cp_hit   = w_hit;
  assign w_dbit     = din;
`endif

  assign w_chk      = (r_pos == POS_LAST);
  assign w_payload  = (r_pos <= PAY_LAST);
  assign w_pos_nxt  = w_chk ? '0 : r_pos + 1'b1;
  assign w_conf_inc = r_conf + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pos         <= '0;
      r_conf        <= '0;
      r_miss        <= '0;
      r_locked      <= 1'b0;
      r_dout_vld    <= 1'b0;
      r_dout        <= 1'b0;
      r_bit_idx     <= '0;
      r_frame_start <= 1'b0;
      r_sync_lost   <= 1'b0;
`ifdef SYNC_INVERT_EN
      r_inv         <= 1'b0;
`endif
    end else begin
      r_dout_vld    <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_lost   <= 1'b0;
      if (!enable) begin
        r_state   <= S_IDLE;
        r_pos     <= '0;
        r_conf    <= '0;
        r_miss    <= '0;
        r_locked  <= 1'b0;
        r_dout    <= 1'b0;
        r_bit_idx <= '0;
`ifdef SYNC_INVERT_EN
        r_inv     <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_HUNT;

          S_HUNT: begin
            // The bit after a hunt hit is frame position 0.
            if (w_hunt_hit) begin
              r_pos  <= '0;
              r_conf <= CW'(1);
`ifdef SYNC_INVERT_EN
              r_inv  <= w_hit_inv;
`endif
              if (CONFIRM_CNT == 1) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state <= S_VERIFY;
              end
            end
          end

          S_VERIFY: begin
            if (din_valid) begin
              r_pos <= w_pos_nxt;
              if (w_chk) begin
                if (w_cp_hit) begin
                  r_conf <= w_conf_inc;
                  if (w_conf_inc == CONF_TGT) begin
                    r_state  <= S_LOCKED;
                    r_locked <= 1'b1;
                  end
                end else begin
                  r_state <= S_HUNT;
                  r_conf  <= '0;
                end
              end
            end
          end

          S_LOCKED: begin
            if (din_valid) begin
              r_pos <= w_pos_nxt;
              if (w_payload) begin
                r_dout_vld    <= 1'b1;
                r_dout        <= w_dbit;
                r_bit_idx     <= r_pos;
                r_frame_start <= (r_pos == '0);
              end
              // Flywheel: isolated misses are tolerated until MISS_CNT in a row.
              if (w_chk) begin
                if (w_cp_hit) begin
                  r_miss <= '0;
                end else if (w_miss_inc == MISS_TGT) begin
                  r_state     <= S_HUNT;
                  r_locked    <= 1'b0;
                  r_sync_lost <= 1'b1;
                  r_miss      <= '0;
                  r_conf      <= '0;
                end else begin
                  r_miss <= w_miss_inc;
                end
              end
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign locked      = r_locked;
  assign dout_valid  = r_dout_vld;
  assign dout        = r_dout;
  assign bit_idx     = r_bit_idx;
  assign frame_start = r_frame_start;
  assign sync_lost   = r_sync_lost;

endmodule
